// File: rtl/reg_file.sv
// Architectural register file with rename (busy/tag) status for the Tomasulo core.
// Commits from the ROB write values and retire matching renames. Issue records new
// renames. Two combinational read ports return either a committed value or the ROB
// tag that will produce it, with a same-cycle commit bypass.
module reg_file #(
  parameter int REG_NUM = 32,
  parameter int TAG_W   = 5,
  parameter int XLEN    = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             en_commit,
  input  logic [TAG_W-1:0] commit_rob,
  input  logic [4:0]       commit_rd,
  input  logic [XLEN-1:0]  commit_val,
  input  logic             issue_in,
  input  logic [4:0]       issue_rd,
  input  logic [TAG_W-1:0] issue_rob,
  input  logic [4:0]       rs1_addr,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [XLEN-1:0]  rs1_val,
  input  logic [4:0]       rs2_addr,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [XLEN-1:0]  rs2_val
);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } rd_res_t;

  // Architectural state; entry 0 is held at zero and never written.
  logic [XLEN-1:0]  val_r      [REG_NUM];
  logic [TAG_W-1:0] tag_r      [REG_NUM];
  logic [REG_NUM-1:0] busy_r;

  logic [XLEN-1:0]  val_nxt_s  [REG_NUM];
  logic [TAG_W-1:0] tag_nxt_s  [REG_NUM];
  logic [REG_NUM-1:0] busy_nxt_s;

  rd_res_t rs1_res_s;
  rd_res_t rs2_res_s;

  // Resolve one operand: x0 is constant zero, a settled register returns its value,
  // a pending register whose producer commits this cycle is bypassed, else the tag.
  function automatic rd_res_t resolve_read(
    input logic             addr_zero,
    input logic             busy,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  val,
    input logic             cmt_en,
    input logic [TAG_W-1:0] cmt_rob,
    input logic [XLEN-1:0]  cmt_val
  );
    rd_res_t res;
    res = '0;
    if (addr_zero) begin
      res = '0;
    end else if (!busy) begin
      res.val = val;
    end else if (cmt_en && (cmt_rob == tag)) begin
      res.val = cmt_val;
    end else begin
      res.busy = 1'b1;
      res.tag  = tag;
    end
    return res;
  endfunction

  // Next-state: commit writes value and retires a matching rename; clear drops all
  // renames; otherwise issue installs a new rename, overriding a same-edge commit.
  always_comb begin
    val_nxt_s  = val_r;
    tag_nxt_s  = tag_r;
    busy_nxt_s = busy_r;
    if (rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (en_commit && (commit_rd == 5'(i))) begin
          val_nxt_s[i] = commit_val;
          if (busy_r[i] && (tag_r[i] == commit_rob)) begin
            busy_nxt_s[i] = 1'b0;
          end else begin
            busy_nxt_s[i] = busy_r[i];
          end
        end else begin
          val_nxt_s[i] = val_r[i];
        end
        if (clear) begin
          busy_nxt_s[i] = 1'b0;
          tag_nxt_s[i]  = {TAG_W{1'b0}};
        end else if (issue_in && (issue_rd == 5'(i))) begin
          busy_nxt_s[i] = 1'b1;
          tag_nxt_s[i]  = issue_rob;
        end else begin
          tag_nxt_s[i]  = tag_r[i];
        end
      end
    end else begin
      val_nxt_s  = val_r;
      tag_nxt_s  = tag_r;
      busy_nxt_s = busy_r;
    end
    val_nxt_s[0]  = {XLEN{1'b0}};
    tag_nxt_s[0]  = {TAG_W{1'b0}};
    busy_nxt_s[0] = 1'b0;
  end

  // State registers with asynchronous clear of every entry.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_r[i] <= {XLEN{1'b0}};
        tag_r[i] <= {TAG_W{1'b0}};
      end
      busy_r <= {REG_NUM{1'b0}};
    end else begin
      val_r  <= val_nxt_s;
      tag_r  <= tag_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Operand read ports, zero latency; they see committed state, not this cycle's issue.
  always_comb begin
    rs1_res_s = resolve_read(rs1_addr == 5'd0, busy_r[rs1_addr], tag_r[rs1_addr],
                             val_r[rs1_addr], en_commit, commit_rob, commit_val);
    rs2_res_s = resolve_read(rs2_addr == 5'd0, busy_r[rs2_addr], tag_r[rs2_addr],
                             val_r[rs2_addr], en_commit, commit_rob, commit_val);
  end

  assign rs1_busy = rs1_res_s.busy;
  assign rs1_tag  = rs1_res_s.tag;
  assign rs1_val  = rs1_res_s.val;
  assign rs2_busy = rs2_res_s.busy;
  assign rs2_tag  = rs2_res_s.tag;
  assign rs2_val  = rs2_res_s.val;

endmodule
